// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bundle: hazard inputs from ID/EX/MEM and the pipeline-register
// enable/clear controls. master = hazard_ctrl, slave = pipeline datapath.
interface hazard_ctrl_if #(
  parameter int REG_W = 5
);
  logic [REG_W-1:0] i_id_rs;
  logic [REG_W-1:0] i_id_rt;
  logic             i_id_uses_rt;
  logic             i_ex_mem_read;
  logic [REG_W-1:0] i_ex_rt;
  logic             i_id_branch_taken;
  logic             i_ex_md_start;
  logic             i_mem_wait;

  // en: 0 = load, 1 = hold; rs: synchronous clear honoured only while en = 0
  logic             o_pc_en;
  logic             o_ifid_en;
  logic             o_idex_en;
  logic             o_exmem_en;
  logic             o_memwb_en;
  logic             o_ifid_rs;
  logic             o_idex_rs;
  logic             o_exmem_rs;
  logic             o_memwb_rs;
  logic             o_md_busy;
  logic [15:0]      o_stall_cnt;

  modport master (
    input  i_id_rs, i_id_rt, i_id_uses_rt, i_ex_mem_read, i_ex_rt,
           i_id_branch_taken, i_ex_md_start, i_mem_wait,
    output o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en,
           o_ifid_rs, o_idex_rs, o_exmem_rs, o_memwb_rs,
           o_md_busy, o_stall_cnt
  );

  modport slave (
    output i_id_rs, i_id_rt, i_id_uses_rt, i_ex_mem_read, i_ex_rt,
           i_id_branch_taken, i_ex_md_start, i_mem_wait,
    input  o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en,
           o_ifid_rs, o_idex_rs, o_exmem_rs, o_memwb_rs,
           o_md_busy, o_stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage MIPS hazard/stall controller: load-use, branch flush, memory wait, mult/div hold.
// Define HAZARD_CTRL_MD_EN to compile in the mult/div EX hold (MD_WAIT state and down-counter).
module hazard_ctrl #(
  parameter int REG_W     = 5,
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = 6
) (
  input logic           clock,
  input logic           i_reset,
  hazard_ctrl_if.master hz
);

  // Reject configurations where the down-counter cannot hold MD_CYCLES-1
  if ((MD_CYCLES < 2) || ((MD_CYCLES - 1) >= (1 << CNT_W))) begin : g_param_check
    $error("hazard_ctrl: MD_CYCLES must be >= 2 and MD_CYCLES-1 must fit in CNT_W bits");
  end

  logic [REG_W-1:0] id_rs_s;
  logic [REG_W-1:0] id_rt_s;
  logic [REG_W-1:0] ex_rt_s;
  logic             lu_s;
  logic             mds_s;

  assign id_rs_s = hz.i_id_rs;
  assign id_rt_s = hz.i_id_rt;
  assign ex_rt_s = hz.i_ex_rt;

  // Register 0 is hardwired, so a load into it never creates a dependency
  assign lu_s = hz.i_ex_mem_read && (ex_rt_s != {REG_W{1'b0}}) &&
                ((ex_rt_s == id_rs_s) || (hz.i_id_uses_rt && (ex_rt_s == id_rt_s)));

`ifdef HAZARD_CTRL_MD_EN
  localparam logic [0:0]       RUN      = 1'b0;
  localparam logic [0:0]       MD_WAIT  = 1'b1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [0:0]       state_r;
  logic [0:0]       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             md_busy_r;

  // Next state: count down to 1 and hold there until memory is ready, then release
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      RUN: begin
        if (hz.i_ex_md_start) begin
          state_nxt_s = MD_WAIT;
          cnt_nxt_s   = CNT_LOAD;
        end else begin
          state_nxt_s = RUN;
          cnt_nxt_s   = CNT_ZERO;
        end
      end
      MD_WAIT: begin
        if (cnt_r > CNT_ONE) begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end else if (!hz.i_mem_wait) begin
          state_nxt_s = RUN;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s = CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = RUN;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // FSM, counter and the registered busy flag
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      state_r   <= RUN;
      cnt_r     <= CNT_ZERO;
      md_busy_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      md_busy_r <= (state_nxt_s == MD_WAIT);
    end
  end

  assign mds_s = ((state_r == RUN) && hz.i_ex_md_start) ||
                 ((state_r == MD_WAIT) && (cnt_r != CNT_ONE));
  assign hz.o_md_busy = md_busy_r;
`else
  assign mds_s        = 1'b0;
  assign hz.o_md_busy = 1'b0;
`endif

  logic pc_en_s, ifid_en_s, idex_en_s, exmem_en_s, memwb_en_s;
  logic ifid_rs_s, idex_rs_s, exmem_rs_s, memwb_rs_s;

  // Priority decode: reset, memory wait, mult/div hold, load-use, taken branch
  always_comb begin
    pc_en_s    = 1'b0;
    ifid_en_s  = 1'b0;
    idex_en_s  = 1'b0;
    exmem_en_s = 1'b0;
    memwb_en_s = 1'b0;
    ifid_rs_s  = 1'b0;
    idex_rs_s  = 1'b0;
    exmem_rs_s = 1'b0;
    memwb_rs_s = 1'b0;
    if (i_reset) begin
      ifid_rs_s  = 1'b1;
      idex_rs_s  = 1'b1;
      exmem_rs_s = 1'b1;
      memwb_rs_s = 1'b1;
    end else if (hz.i_mem_wait) begin
      pc_en_s    = 1'b1;
      ifid_en_s  = 1'b1;
      idex_en_s  = 1'b1;
      exmem_en_s = 1'b1;
      memwb_rs_s = 1'b1;
    end else if (mds_s) begin
      pc_en_s    = 1'b1;
      ifid_en_s  = 1'b1;
      idex_en_s  = 1'b1;
      exmem_rs_s = 1'b1;
    end else if (lu_s) begin
      // A taken branch here is dropped; it re-resolves once the load clears
      pc_en_s   = 1'b1;
      ifid_en_s = 1'b1;
      idex_rs_s = 1'b1;
    end else if (hz.i_id_branch_taken) begin
      ifid_rs_s = 1'b1;
    end else begin
      pc_en_s = 1'b0;
    end
  end

  assign hz.o_pc_en    = pc_en_s;
  assign hz.o_ifid_en  = ifid_en_s;
  assign hz.o_idex_en  = idex_en_s;
  assign hz.o_exmem_en = exmem_en_s;
  assign hz.o_memwb_en = memwb_en_s;
  assign hz.o_ifid_rs  = ifid_rs_s;
  assign hz.o_idex_rs  = idex_rs_s;
  assign hz.o_exmem_rs = exmem_rs_s;
  assign hz.o_memwb_rs = memwb_rs_s;

  logic [15:0] stall_cnt_r;

  // Saturating count of cycles in which the PC was held
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      stall_cnt_r <= 16'h0000;
    end else if (pc_en_s && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign hz.o_stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomised and directed bench for hazard_ctrl against a cycle-level reference model.
module tb_hazard_ctrl;
  localparam int MD_CYCLES = 4;
`ifdef HAZARD_CTRL_MD_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic clock;
  logic i_reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic id_uses_rt, ex_mem_read, branch, md_start, mem_wait;

  int checks = 0;
  int errors = 0;

  // Reference state: op in flight, its age in EX (start cycle = 0), stall tally
  bit m_busy;
  int m_age;
  int m_stall;

  hazard_ctrl_if #(.REG_W(5)) hz ();

  assign hz.i_id_rs           = id_rs;
  assign hz.i_id_rt           = id_rt;
  assign hz.i_id_uses_rt      = id_uses_rt;
  assign hz.i_ex_mem_read     = ex_mem_read;
  assign hz.i_ex_rt           = ex_rt;
  assign hz.i_id_branch_taken = branch;
  assign hz.i_ex_md_start     = md_start;
  assign hz.i_mem_wait        = mem_wait;

  hazard_ctrl #(.REG_W(5), .MD_CYCLES(MD_CYCLES), .CNT_W(3)) dut (
    .clock  (clock),
    .i_reset(i_reset),
    .hz     (hz)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // {pc,ifid,idex,exmem,memwb en, ifid,idex,exmem,memwb rs}
  function automatic logic [8:0] ctrl_obs();
    return {hz.o_pc_en, hz.o_ifid_en, hz.o_idex_en, hz.o_exmem_en, hz.o_memwb_en,
            hz.o_ifid_rs, hz.o_idex_rs, hz.o_exmem_rs, hz.o_memwb_rs};
  endfunction

  function automatic bit model_lu();
    return ex_mem_read && (ex_rt != 5'd0) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  endfunction

  function automatic logic [8:0] model_ctrl();
    bit md_hold;
    md_hold = MD_EN && ((!m_busy && md_start) || (m_busy && (m_age < MD_CYCLES - 1)));
    if (i_reset)       return 9'b00000_1111;
    else if (mem_wait) return 9'b11110_0001;
    else if (md_hold)  return 9'b11100_0010;
    else if (model_lu()) return 9'b11000_0100;
    else if (branch)   return 9'b00000_1000;
    else               return 9'b00000_0000;
  endfunction

  task automatic set_idle();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    id_uses_rt = 1'b0; ex_mem_read = 1'b0; branch = 1'b0;
    md_start = 1'b0; mem_wait = 1'b0;
  endtask

  // Advance one clock edge, stepping the model with the inputs seen at that edge
  task automatic tick();
    logic [8:0] e;
    e = model_ctrl();
    @(posedge clock);
    if (i_reset) begin
      m_busy = 1'b0; m_age = 0; m_stall = 0;
    end else begin
      if (e[8] && (m_stall < 65535)) m_stall++;
      if (MD_EN) begin
        if (!m_busy) begin
          if (md_start) begin m_busy = 1'b1; m_age = 1; end
        end else if ((m_age >= MD_CYCLES - 1) && !mem_wait) begin
          m_busy = 1'b0; m_age = 0;
        end else begin
          m_age++;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    set_idle();
    tick();
    tick();
    #2;
    checks++;
    if (ctrl_obs() !== 9'b00000_1111) begin
      errors++; $display("FAIL reset_ctrl got %b exp %b", ctrl_obs(), 9'b00000_1111);
    end
    checks++;
    if (hz.o_md_busy !== 1'b0 || hz.o_stall_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_regs busy %b cnt %0d exp 0 0", hz.o_md_busy, hz.o_stall_cnt);
    end
    tick();
    i_reset = 1'b0;
    #2;
    checks++;
    if (ctrl_obs() !== 9'b00000_0000) begin
      errors++; $display("FAIL post_reset_ctrl got %b exp %b", ctrl_obs(), 9'b0);
    end
    tick();
  endtask

  task automatic test_load_use();
    set_idle();
    ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    #2;
    checks++;
    if (ctrl_obs() !== model_ctrl() || hz.o_idex_rs !== 1'b1 || hz.o_pc_en !== 1'b1) begin
      errors++; $display("FAIL lu_rs got %b exp %b", ctrl_obs(), model_ctrl());
    end
    tick();
    ex_rt = 5'd0; id_rs = 5'd0;
    #2;
    checks++;
    if (ctrl_obs() !== 9'b00000_0000) begin
      errors++; $display("FAIL lu_r0 got %b exp %b", ctrl_obs(), 9'b0);
    end
    tick();
    ex_rt = 5'd7; id_rs = 5'd1; id_rt = 5'd7; id_uses_rt = 1'b1;
    #2;
    checks++;
    if (ctrl_obs() !== 9'b11000_0100) begin
      errors++; $display("FAIL lu_rt got %b exp %b", ctrl_obs(), 9'b11000_0100);
    end
    tick();
    id_uses_rt = 1'b0;
    #2;
    checks++;
    if (ctrl_obs() !== 9'b00000_0000) begin
      errors++; $display("FAIL lu_rt_unused got %b exp %b", ctrl_obs(), 9'b0);
    end
    tick();
    checks++;
    if (hz.o_stall_cnt !== 16'(m_stall)) begin
      errors++; $display("FAIL lu_stall_cnt got %0d exp %0d", hz.o_stall_cnt, m_stall);
    end
    set_idle();
  endtask

  task automatic test_branch();
    set_idle();
    branch = 1'b1;
    #2;
    checks++;
    if (ctrl_obs() !== 9'b00000_1000) begin
      errors++; $display("FAIL branch got %b exp %b", ctrl_obs(), 9'b00000_1000);
    end
    tick();
    ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    #2;
    checks++;
    if (ctrl_obs() !== 9'b11000_0100 || hz.o_ifid_rs !== 1'b0) begin
      errors++; $display("FAIL branch_lu got %b exp %b", ctrl_obs(), 9'b11000_0100);
    end
    tick();
    set_idle();
  endtask

  task automatic test_md();
    int start_len;
    int busy_seen;
    int hold_seen;
    int stall0;
    set_idle();
    start_len = MD_EN ? 1 : 5;
    busy_seen = 0;
    hold_seen = 0;
    stall0 = m_stall;
    for (int i = 0; i < 9; i++) begin
      md_start = (i < start_len);
      #2;
      checks++;
      if (ctrl_obs() !== model_ctrl() || hz.o_md_busy !== m_busy) begin
        errors++; $display("FAIL md_cycle%0d ctrl %b exp %b busy %b exp %b",
                           i, ctrl_obs(), model_ctrl(), hz.o_md_busy, m_busy);
      end
      if (hz.o_md_busy === 1'b1) busy_seen++;
      if (hz.o_pc_en === 1'b1 && hz.o_exmem_rs === 1'b1) hold_seen++;
      tick();
    end
    checks++;
    if (busy_seen != (MD_EN ? 3 : 0) || hold_seen != (MD_EN ? 3 : 0)) begin
      errors++; $display("FAIL md_len busy %0d hold %0d exp %0d", busy_seen, hold_seen, MD_EN ? 3 : 0);
    end
    checks++;
    if (hz.o_stall_cnt !== 16'(stall0 + (MD_EN ? 3 : 0))) begin
      errors++; $display("FAIL md_stall_cnt got %0d exp %0d", hz.o_stall_cnt, stall0 + (MD_EN ? 3 : 0));
    end
    set_idle();
  endtask

  task automatic test_mem_wait_md();
    set_idle();
    for (int i = 0; i < 7; i++) begin
      md_start = (i == 0);
      mem_wait = (i == 3) || (i == 4);
      #2;
      checks++;
      if (ctrl_obs() !== model_ctrl() || hz.o_md_busy !== m_busy) begin
        errors++; $display("FAIL mw_cycle%0d ctrl %b exp %b busy %b exp %b",
                           i, ctrl_obs(), model_ctrl(), hz.o_md_busy, m_busy);
      end
      if (mem_wait) begin
        checks++;
        if (ctrl_obs() !== 9'b11110_0001 || hz.o_md_busy !== MD_EN) begin
          errors++; $display("FAIL mw_hold got %b busy %b exp %b busy %b",
                             ctrl_obs(), hz.o_md_busy, 9'b11110_0001, MD_EN);
        end
      end
      tick();
      if (i == 5) begin
        checks++;
        if (hz.o_md_busy !== 1'b0) begin
          errors++; $display("FAIL mw_release busy %b exp 0", hz.o_md_busy);
        end
      end
    end
    set_idle();
  endtask

  task automatic test_async_reset();
    set_idle();
    md_start = 1'b1;
    tick();
    md_start = 1'b0;
    tick();
    #2;
    i_reset = 1'b1;
    m_busy = 1'b0; m_age = 0; m_stall = 0;
    #1;
    checks++;
    if (hz.o_md_busy !== 1'b0 || hz.o_stall_cnt !== 16'd0 || ctrl_obs() !== 9'b00000_1111) begin
      errors++; $display("FAIL async_reset busy %b cnt %0d ctrl %b exp 0 0 %b",
                         hz.o_md_busy, hz.o_stall_cnt, ctrl_obs(), 9'b00000_1111);
    end
    tick();
    checks++;
    if (ctrl_obs() !== 9'b00000_1111 || hz.o_md_busy !== 1'b0) begin
      errors++; $display("FAIL reset_held ctrl %b busy %b exp %b 0", ctrl_obs(), hz.o_md_busy, 9'b00000_1111);
    end
    i_reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++;
      if (ctrl_obs() !== 9'b00000_0000 || hz.o_md_busy !== 1'b0 || hz.o_stall_cnt !== 16'd0) begin
        errors++; $display("FAIL after_reset%0d ctrl %b busy %b cnt %0d exp 0",
                           i, ctrl_obs(), hz.o_md_busy, hz.o_stall_cnt);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      id_rs       = 5'($urandom_range(0, 3));
      id_rt       = 5'($urandom_range(0, 3));
      ex_rt       = 5'($urandom_range(0, 3));
      id_uses_rt  = ($urandom_range(0, 1) == 1);
      ex_mem_read = ($urandom_range(0, 1) == 1);
      branch      = ($urandom_range(0, 2) == 0);
      md_start    = ($urandom_range(0, 7) == 0);
      mem_wait    = ($urandom_range(0, 5) == 0);
      #2;
      checks++;
      if (ctrl_obs() !== model_ctrl() || hz.o_md_busy !== m_busy ||
          hz.o_stall_cnt !== 16'(m_stall)) begin
        errors++; $display("FAIL rand%0d ctrl %b exp %b busy %b exp %b cnt %0d exp %0d",
                           i, ctrl_obs(), model_ctrl(), hz.o_md_busy, m_busy,
                           hz.o_stall_cnt, m_stall);
      end
      tick();
    end
    set_idle();
  endtask

  initial begin
    m_busy = 1'b0; m_age = 0; m_stall = 0;
    test_reset();
    test_load_use();
    test_branch();
    test_md();
    test_mem_wait_md();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
